// File: rtl/mem_arbiter_pkg.sv
// Shared types for the program-memory arbiter: requester tags and reset constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } src_t;

  // Requester A wins the first tie after reset.
  localparam src_t RESET_LAST = SRC_B;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the program ram.
interface mem_arbiter_if #(
  parameter int n = 8
);
  import mem_arb_pkg::*;

  // Handshake: a requester raises Req with a stable Addr; the access is
  // accepted at the rising edge where Req & Gnt are both high. Gnt is
  // combinational. Valid is a one-cycle pulse two cycles after the accept
  // while Data holds the result; there is no backpressure on the return.
  logic         ReqA;
  logic [n-1:0] AddrA;
  logic         GntA;
  logic [n-1:0] DataA;
  logic         ValidA;

  logic         ReqB;
  logic [n-1:0] AddrB;
  logic         GntB;
  logic [n-1:0] DataB;
  logic         ValidB;

  logic [n-1:0] MemAddr;
  logic [n-1:0] MemData;

  // Internal pipeline state exposed for observation.
  src_t         dbg_last;
  src_t         dbg_tag1;

  modport slave (
    input  ReqA, AddrA, ReqB, AddrB, MemData,
    output GntA, DataA, ValidA, GntB, DataB, ValidB, MemAddr,
    output dbg_last, dbg_tag1
  );

  modport master (
    output ReqA, AddrA, ReqB, AddrB, MemData,
    input  GntA, DataA, ValidA, GntB, DataB, ValidB, MemAddr,
    input  dbg_last, dbg_tag1
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester that did
// not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic reqa,
  input  logic reqb,
  input  src_t last,
  output logic gnta,
  output logic gntb,
  output src_t winner
);

  always_comb begin
    gnta   = 1'b0;
    gntb   = 1'b0;
    winner = SRC_NONE;
    if (reqa && reqb) begin
      if (last == SRC_A) begin
        gntb   = 1'b1;
        winner = SRC_B;
      end else begin
        gnta   = 1'b1;
        winner = SRC_A;
      end
    end else if (reqa) begin
      gnta   = 1'b1;
      winner = SRC_A;
    end else if (reqb) begin
      gntb   = 1'b1;
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a combinational-read program ram between the
// cpu fetch port (A) and the debug monitor port (B), two-cycle read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic          Clock,
  input  logic          Reset,
  mem_arbiter_if.slave  bus
);

  src_t         last_q, last_d;
  src_t         tag1_q, tag1_d;
  src_t         pick_winner;
  logic [n-1:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] data_a_q, data_a_d;
  logic [n-1:0] data_b_q, data_b_d;
  logic         valid_a_q, valid_a_d;
  logic         valid_b_q, valid_b_d;
  logic         pick_gnta, pick_gntb;
  logic         gnt_a, gnt_b;
  logic         acc_a, acc_b;

  rr_pick2 u_pick (
    .reqa   (bus.ReqA),
    .reqb   (bus.ReqB),
    .last   (last_q),
    .gnta   (pick_gnta),
    .gntb   (pick_gntb),
    .winner (pick_winner)
  );

  // Reset overrides any request so no accept can slip through it.
  assign gnt_a = pick_gnta & ~Reset;
  assign gnt_b = pick_gntb & ~Reset;
  assign acc_a = bus.ReqA & gnt_a;
  assign acc_b = bus.ReqB & gnt_b;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_q     <= RESET_LAST;
      tag1_q     <= SRC_NONE;
      mem_addr_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      tag1_q     <= tag1_d;
      mem_addr_q <= mem_addr_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
    end
  end

  always_comb begin
    last_d     = last_q;
    tag1_d     = SRC_NONE;
    mem_addr_d = mem_addr_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    valid_a_d  = 1'b0;
    valid_b_d  = 1'b0;

    // Stage 0: issue the accepted address to ram and remember who owns it.
    if (acc_a || acc_b) begin
      mem_addr_d = acc_a ? bus.AddrA : bus.AddrB;
      tag1_d     = pick_winner;
      last_d     = pick_winner;
    end

    // Stage 1: ram data for last cycle's address is returned to its owner.
    case (tag1_q)
      SRC_A: begin
        data_a_d  = bus.MemData;
        valid_a_d = 1'b1;
      end
      SRC_B: begin
        data_b_d  = bus.MemData;
        valid_b_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.GntA     = gnt_a;
    bus.GntB     = gnt_b;
    bus.MemAddr  = mem_addr_q;
    bus.DataA    = data_a_q;
    bus.ValidA   = valid_a_q;
    bus.DataB    = data_b_q;
    bus.ValidB   = valid_b_q;
    bus.dbg_last = last_q;
    bus.dbg_tag1 = tag1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vectors with hand-computed grants,
// ram address and return data, plus an issue-order scoreboard per requester.
module tb_mem_arbiter;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];

  mem_arbiter_if #(.n(8)) bus ();

  mem_arbiter #(.n(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Ram model: mem[a] = a ^ 8'h5A, combinational read.
  assign bus.MemData = bus.MemAddr ^ 8'h5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check a little later.
  task automatic step(input logic rst,
                      input logic ra, input logic [7:0] aa,
                      input logic rb, input logic [7:0] ab,
                      input logic ga, input logic gb, input logic [7:0] ma,
                      input logic va, input logic [7:0] da,
                      input logic vb, input logic [7:0] db);
    @(posedge Clock);
    #1;
    Reset     = rst;
    bus.ReqA  = ra;
    bus.AddrA = aa;
    bus.ReqB  = rb;
    bus.AddrB = ab;
    #2;
    check("GntA",    {31'd0, bus.GntA},   {31'd0, ga});
    check("GntB",    {31'd0, bus.GntB},   {31'd0, gb});
    check("MemAddr", {24'd0, bus.MemAddr}, {24'd0, ma});
    check("ValidA",  {31'd0, bus.ValidA}, {31'd0, va});
    check("DataA",   {24'd0, bus.DataA},  {24'd0, da});
    check("ValidB",  {31'd0, bus.ValidB}, {31'd0, vb});
    check("DataB",   {24'd0, bus.DataB},  {24'd0, db});
    if (bus.ValidA) begin
      if (exp_qa.size() == 0) check("sb_a_underflow", 32'd1, 32'd0);
      else check("sb_a_order", {24'd0, bus.DataA}, {24'd0, exp_qa.pop_front()});
    end
    if (bus.ValidB) begin
      if (exp_qb.size() == 0) check("sb_b_underflow", 32'd1, 32'd0);
      else check("sb_b_order", {24'd0, bus.DataB}, {24'd0, exp_qb.pop_front()});
    end
    if (rst) begin
      exp_qa.delete();
      exp_qb.delete();
    end
    if (ra && ga) exp_qa.push_back(aa ^ 8'h5A);
    if (rb && gb) exp_qb.push_back(ab ^ 8'h5A);
  endtask

  task automatic idle(input logic [7:0] ma, input logic va, input logic [7:0] da,
                      input logic vb, input logic [7:0] db);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, ma, va, da, vb, db);
  endtask

  initial begin
    Reset     = 1'b1;
    bus.ReqA  = 1'b0;
    bus.AddrA = 8'h00;
    bus.ReqB  = 1'b0;
    bus.AddrB = 8'h00;

    // Reset held two cycles with both requests high: nothing granted.
    step(1, 1, 8'h77, 1, 8'h66, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    step(1, 1, 8'h77, 1, 8'h66, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    idle(8'h00, 0, 8'h00, 0, 8'h00);

    // Single A read at 8'h10.
    step(0, 1, 8'h10, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    idle(8'h10, 0, 8'h00, 0, 8'h00);
    idle(8'h10, 1, 8'h4A, 0, 8'h00);
    idle(8'h10, 0, 8'h4A, 0, 8'h00);

    // One-cycle reset so last-winner returns to B.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h10, 0, 8'h4A, 0, 8'h00);

    // Tie after reset: grants A,B,A,B.
    step(0, 1, 8'h01, 1, 8'h02, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h01, 1, 8'h02, 0, 1, 8'h01, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h01, 1, 8'h02, 1, 0, 8'h02, 1, 8'h5B, 0, 8'h00);
    step(0, 1, 8'h01, 1, 8'h02, 0, 1, 8'h01, 0, 8'h5B, 1, 8'h58);
    idle(8'h02, 1, 8'h5B, 0, 8'h58);
    idle(8'h02, 0, 8'h5B, 1, 8'h58);
    idle(8'h02, 0, 8'h5B, 0, 8'h58);

    // Burst B alone at 20,21,22; DataA untouched.
    step(0, 0, 8'h00, 1, 8'h20, 0, 1, 8'h02, 0, 8'h5B, 0, 8'h58);
    step(0, 0, 8'h00, 1, 8'h21, 0, 1, 8'h20, 0, 8'h5B, 0, 8'h58);
    step(0, 0, 8'h00, 1, 8'h22, 0, 1, 8'h21, 0, 8'h5B, 1, 8'h7A);
    idle(8'h22, 0, 8'h5B, 1, 8'h7B);
    idle(8'h22, 0, 8'h5B, 1, 8'h78);
    idle(8'h22, 0, 8'h5B, 0, 8'h78);

    // Reset mid-flight: the access to 8'h30 never returns.
    step(0, 1, 8'h30, 0, 8'h00, 1, 0, 8'h22, 0, 8'h5B, 0, 8'h78);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h30, 0, 8'h5B, 0, 8'h78);
    idle(8'h00, 0, 8'h00, 0, 8'h00);
    step(0, 1, 8'h31, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    idle(8'h31, 0, 8'h00, 0, 8'h00);
    idle(8'h31, 1, 8'h6B, 0, 8'h00);
    idle(8'h31, 0, 8'h6B, 0, 8'h00);

    // Late joiner: A bursts from 8'h00, B joins in cycle 3 at 8'hFF.
    step(0, 1, 8'h00, 0, 8'h00, 1, 0, 8'h31, 0, 8'h6B, 0, 8'h00);
    step(0, 1, 8'h01, 0, 8'h00, 1, 0, 8'h00, 0, 8'h6B, 0, 8'h00);
    step(0, 1, 8'h02, 0, 8'h00, 1, 0, 8'h01, 1, 8'h5A, 0, 8'h00);
    step(0, 1, 8'h03, 1, 8'hFF, 0, 1, 8'h02, 1, 8'h5B, 0, 8'h00);
    step(0, 1, 8'h03, 0, 8'h00, 1, 0, 8'hFF, 1, 8'h58, 0, 8'h00);
    step(0, 1, 8'h04, 0, 8'h00, 1, 0, 8'h03, 0, 8'h58, 1, 8'hA5);
    idle(8'h04, 1, 8'h59, 0, 8'hA5);
    idle(8'h04, 1, 8'h5E, 0, 8'hA5);
    idle(8'h04, 0, 8'h5E, 0, 8'hA5);

    check("sb_a_left", exp_qa.size(), 32'd0);
    check("sb_b_left", exp_qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single combinational-read program memory (ram: Address in, Data out) between two requesters: A = cpu instruction/operand fetch, B = debug/monitor port (switch-selected memory dump to LEDs).
- Round-robin, one access issued per cycle, fixed 2-cycle read latency, per-requester data/valid return path.
- Sits between cpu/monitor and ram; drives MemAddr, receives MemData.

Parameters:
- n, 8, address and data width (matches cpu n).

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqA  input  1  requester A wants an access this cycle.
- AddrA  input  n  requester A read address; stable while ReqA high and GntA low.
- GntA  output  1  combinational; access accepted at this edge when ReqA & GntA.
- DataA  output  n  registered read data for A.
- ValidA  output  1  one-cycle pulse: DataA holds a new result.
- ReqB, AddrB, GntB, DataB, ValidB: same as A, for requester B.
- MemAddr  output  n  registered address to ram.
- MemData  input  n  ram read data, combinational from MemAddr.

Behaviour:
- Reset values: MemAddr=0, DataA=DataB=0, ValidA=ValidB=0, stage-1 tag=SRC_NONE, last-winner=SRC_B (A wins the first tie). GntA=GntB=0 while Reset=1.
- Grant, combinational in cycle t: only ReqA -> GntA; only ReqB -> GntB; both -> grant the requester that is not last-winner; neither -> no grant. At most one Gnt high. Gnt does not depend on Gnt.
- Accept edge ending cycle t with Req&Gnt: MemAddr<=winner Addr; tag1<=winner; last-winner<=winner. With no accept: MemAddr holds, tag1<=SRC_NONE, last-winner holds.
- Cycle t+1: ram drives MemData from MemAddr. At the edge ending t+1: if tag1=SRC_A then DataA<=MemData and ValidA<=1; if SRC_B, the same for B. The other Valid is 0. Data of the non-selected requester holds.
- Latency: Valid high in cycle t+2 for a request accepted at the end of cycle t. Throughput: one access per cycle. Pipelined accesses to alternating or identical requesters return in issue order.
- Requester keeping Req high after an accept issues a new access (burst). Under contention the grant alternates every cycle. Bound on starvation: 1 cycle.
- Valid is a pulse, not a level. Requesters have no backpressure and must capture Data in the Valid cycle.
- Address wrap: none. MemAddr is the n-bit address passed straight through.
- Reset mid-operation: in-flight tag1 is discarded. No Valid is produced for it after Reset deasserts. Next Valid comes from a fresh accept.
- Simultaneous Reset and Req: Reset wins. No accept occurs and no state updates except reset values.

Decomposition:
- Package mem_arb_pkg: typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B} src_t. Constant RESET_LAST = SRC_B.
- Sub-module rr_pick2: combinational 2-way round-robin picker (reqa, reqb, last -> gnta, gntb, winner). mem_arbiter holds the last-winner register, the address/tag pipeline and the return registers.

Test Plan:
- Bench ram model has mem[a] = a ^ 8'h5A. Clock and Reset are driven as in the cpu bench, with Reset high for 1 cycle.
- Reset: hold Reset 2 cycles with ReqA=ReqB=1 -> GntA=GntB=0, MemAddr=0, ValidA=ValidB=0, DataA=DataB=0 throughout.
- Single A read: ReqA=1, AddrA=8'h10 for 1 cycle (t) -> GntA=1 in t; MemAddr=8'h10 in t+1; ValidA=1, DataA=8'h4A in t+2 only; ValidB stays 0.
- Tie after reset: ReqA=ReqB=1, AddrA=8'h01, AddrB=8'h02, held 4 cycles -> grants A,B,A,B. Returns A:8'h5B, B:8'h58, A:8'h5B, B:8'h58 on consecutive cycles, each 2 cycles after its grant.
- Burst B alone: ReqB=1 with AddrB=8'h20,21,22 on 3 consecutive cycles -> GntB=1 each cycle; ValidB high 3 consecutive cycles with DataB=8'h7A,8'h7B,8'h78; DataA unchanged.
- Reset mid-flight: A accepted at AddrA=8'h30, Reset asserted in the next cycle for 1 cycle -> no ValidA ever produced for 8'h30; after release, a new ReqA at 8'h31 returns 8'h6B with latency 2.
- Late joiner: ReqA bursts at 8'h00..; ReqB asserted in cycle 3 with AddrB=8'hFF -> GntB within 1 cycle; DataB=8'hA5; A resumes the next cycle with no address skipped.
